// File: rtl/dff_reg_arbiter_pkg.sv
// Shared encodings for the round-robin register arbiter: FSM states,
// register-bank operations, requester indices and the default width.
package dff_reg_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BANK_HOLD  = 2'd0,
        BANK_LOAD  = 2'd1,
        BANK_SHIFT = 2'd2,
        BANK_CLEAR = 2'd3
    } bank_op_t;

    localparam logic REQ_IDX0 = 1'b0;
    localparam logic REQ_IDX1 = 1'b1;

endpackage

// File: rtl/dff_reg_bank.sv
// Storage register built from D flip-flop cells; each bit has its own
// next-value mux for hold, parallel load, right shift (MSB insert) and clear.
module dff_cell (
    input  logic clk,
    input  logic d,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        q <= d;
    end

    assign qn = ~q;

endmodule

module dff_reg_bank
    import dff_reg_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shift_in;
        logic d_nxt;

        // The MSB takes the serial input; every other bit takes its upper neighbour.
        if (i == WIDTH - 1) begin : g_msb
            assign shift_in = sin;
        end else begin : g_low
            assign shift_in = q[i+1];
        end

        always_comb begin
            d_nxt = q[i];
            case (op)
                BANK_LOAD:  d_nxt = d[i];
                BANK_SHIFT: d_nxt = shift_in;
                BANK_CLEAR: d_nxt = 1'b0;
                default:    d_nxt = q[i];
            endcase
        end

        dff_cell u_dff (
            .clk (clk),
            .d   (d_nxt),
            .q   (q[i]),
            .qn  (qn[i])
        );
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting one shared register to two requesters; each
// grant performs a parallel load or an LSB-first serial shift-in, then DONE.
module dff_reg_arbiter
    import dff_reg_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             C,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic             SER0,
    input  logic             SER1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qnot
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic             gnt0, gnt0_nxt;
    logic             gnt1, gnt1_nxt;
    logic             done, done_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             win;
    bank_op_t         bank_op;

    always_ff @(posedge C) begin
        if (RST) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done  <= 1'b0;
            last  <= REQ_IDX1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt0  <= gnt0_nxt;
            gnt1  <= gnt1_nxt;
            done  <= done_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // HOLD is pure data: it is only meaningful once a grant has latched it.
    always_ff @(posedge C) begin
        hold <= hold_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt0_nxt  = gnt0;
        gnt1_nxt  = gnt1;
        done_nxt  = done;
        last_nxt  = last;
        cnt_nxt   = cnt;
        hold_nxt  = hold;
        win       = REQ_IDX0;
        bank_op   = BANK_HOLD;

        case (state)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    // On a tie the requester that did not win last time goes next.
                    win       = (REQ0 && REQ1) ? ~last : REQ1;
                    hold_nxt  = win ? D1 : D0;
                    last_nxt  = win;
                    gnt0_nxt  = ~win;
                    gnt1_nxt  = win;
                    cnt_nxt   = '0;
                    state_nxt = (win ? SER1 : SER0) ? SHIFT : LOAD;
                end
            end
            LOAD: begin
                bank_op   = BANK_LOAD;
                done_nxt  = 1'b1;
                state_nxt = FIN;
            end
            SHIFT: begin
                bank_op = BANK_SHIFT;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
                done_nxt  = 1'b0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (RST) begin
            bank_op = BANK_CLEAR;
        end
    end

    dff_reg_bank #(.WIDTH(WIDTH)) u_bank (
        .clk (C),
        .op  (bank_op),
        .d   (hold),
        .sin (hold[cnt]),
        .q   (Q),
        .qn  (Qnot)
    );

    assign GNT0 = gnt0;
    assign GNT1 = gnt1;
    assign DONE = done;
    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboard bench for dff_reg_arbiter: a transaction-level model predicts the
// outputs after every edge; a negedge monitor pops and compares them.
module tb_dff_reg_arbiter;

    localparam int W = 4;

    logic         C, RST, REQ0, REQ1, SER0, SER1;
    logic [W-1:0] D0, D1;
    logic         GNT0, GNT1, BUSY, DONE;
    logic [W-1:0] Q, Qnot;

    dff_reg_arbiter #(.WIDTH(W)) dut (
        .C    (C),
        .RST  (RST),
        .REQ0 (REQ0),
        .REQ1 (REQ1),
        .D0   (D0),
        .D1   (D1),
        .SER0 (SER0),
        .SER1 (SER1),
        .GNT0 (GNT0),
        .GNT1 (GNT1),
        .BUSY (BUSY),
        .DONE (DONE),
        .Q    (Q),
        .Qnot (Qnot)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic [3:0]   ctl;   // {GNT0, GNT1, BUSY, DONE}
        logic [W-1:0] q;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    // Transaction-level model state
    int           m_pos = 0;    // edges since the grant edge, 0 = idle
    logic         m_w, m_ser;
    logic         m_last = 1'b1;
    logic [W-1:0] m_h, m_p;
    logic [W-1:0] m_q = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp, input int cyc);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got[7:0], exp[7:0]);
        end
    endtask

    task automatic step(input logic rst, input logic r0, input logic r1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic s0, input logic s1);
        exp_t             e;
        int               len;
        logic             dn;
        logic [2*W-1:0]   wide;
        RST = rst; REQ0 = r0; REQ1 = r1; D0 = d0; D1 = d1; SER0 = s0; SER1 = s1;
        e.cyc = cyc_cnt;
        if (rst) begin
            m_pos = 0; m_q = '0; m_last = 1'b1;
            e.ctl = 4'b0000; e.q = '0;
        end else if (m_pos == 0) begin
            if (r0 || r1) begin
                m_w    = (r0 && r1) ? ~m_last : r1;
                m_h    = m_w ? d1 : d0;
                m_ser  = m_w ? s1 : s0;
                m_last = m_w;
                m_p    = m_q;
                m_pos  = 1;
                e.ctl  = {~m_w, m_w, 1'b1, 1'b0};
            end else begin
                e.ctl = 4'b0000;
            end
            e.q = m_q;
        end else begin
            len = m_ser ? W + 1 : 2;
            if (m_pos == len) begin
                m_pos = 0;
                e.ctl = 4'b0000;
            end else begin
                if (m_ser) begin
                    // After j shifts the register shows HOLD's low j bits on top
                    // of the old contents moved down by j places.
                    wide = {m_h, m_p};
                    m_q  = W'(wide >> m_pos);
                    dn   = (m_pos == W);
                end else begin
                    m_q = m_h;
                    dn  = 1'b1;
                end
                e.ctl = {~m_w, m_w, 1'b1, dn};
                m_pos++;
            end
            e.q = m_q;
        end
        sb.push_back(e);
        @(posedge C);
        cyc_cnt++;
        @(negedge C);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic settle();
        for (int i = 0; i < W + 3 && m_pos != 0; i++) idle_steps(1);
    endtask

    // Monitor: one expected record per edge, compared half a cycle later
    always @(negedge C) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ctl_gnt0_gnt1_busy_done", {28'd0, GNT0, GNT1, BUSY, DONE}, {28'd0, e.ctl}, e.cyc);
            chk("q", {28'd0, Q}, {28'd0, e.q}, e.cyc);
            chk("qnot", {28'd0, Qnot}, {28'd0, ~e.q}, e.cyc);
            chk("gnt_exclusive", {31'd0, GNT0 & GNT1}, 32'd0, e.cyc);
        end
    end

    initial begin
        // Reset with random request noise
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        // Single parallel load from requester 0
        step(1'b0, 1'b1, 1'b0, 4'b1010, W'($urandom), 1'b0, 1'($urandom));
        idle_steps(3);

        // Continuous contention, both parallel: grants must alternate
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 4'b0011, 4'b1100, 1'b0, 1'b0);
        settle();
        idle_steps(1);

        // Serial shift-in from requester 1
        step(1'b0, 1'b0, 1'b1, W'($urandom), 4'b1011, 1'($urandom), 1'b1);
        idle_steps(6);

        // Serial transfer aborted by reset after two shifts, then a tie
        step(1'b0, 1'b1, 1'b0, 4'b1111, W'($urandom), 1'b1, 1'b0);
        idle_steps(2);
        step(1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'b0110, 4'b1001, 1'b0, 1'b0);
        settle();
        idle_steps(1);

        // Requester 0 drops mid-transfer while requester 1 waits
        step(1'b0, 1'b1, 1'b0, 4'b0101, W'($urandom), 1'b1, 1'($urandom));
        for (int i = 0; i < W + 4; i++)
            step(1'b0, 1'b0, 1'b1, W'($urandom), 4'b1110, 1'($urandom), 1'b0);
        settle();

        // Random traffic, including occasional reset mid-transaction
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
                 W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        idle_steps(W + 3);

        @(negedge C);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0, cyc_cnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
